// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: geometry, entry encoding and field types.
// DEPTH must be a power of two so that the pointers wrap by natural overflow.
package reorder_buffer_pkg;

  localparam int DEPTH       = 16;
  localparam int TAG_W       = 5;
  localparam int PTR_W       = TAG_W - 1;
  localparam int CNT_W       = TAG_W + 1;
  localparam int RegAddrSize = 5;
  localparam int InstSize    = 32;
  localparam int DataSize    = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2
  } entry_state_e;

  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [PTR_W-1:0]       ptr_t;
  typedef logic [CNT_W-1:0]       cnt_t;
  typedef logic [RegAddrSize-1:0] reg_addr_t;
  typedef logic [InstSize-1:0]    inst_t;
  typedef logic [DataSize-1:0]    data_t;

  typedef struct packed {
    entry_state_e state;
    reg_addr_t    rd;
    data_t        val;
    logic         mispredict;
    data_t        target;
    inst_t        inst;
  } rob_entry_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand query, commit broadcast and flush signals of the reorder buffer.
// The ROB side is the slave; the core (issue/ALU/listeners) is the master.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic      alloc_en;
  reg_addr_t alloc_rd;
  inst_t     alloc_inst;
  tag_t      alloc_tag;
  logic      rob_full;

  logic      wb_en;
  tag_t      wb_tag;
  data_t     wb_val;
  logic      wb_mispredict;
  data_t     wb_target;

  tag_t      query_tag1;
  tag_t      query_tag2;
  logic      query_ready1;
  logic      query_ready2;
  data_t     query_val1;
  data_t     query_val2;

  logic      commit_en;
  tag_t      commit_Number;
  data_t     commit_val;
  reg_addr_t commit_rd;
  logic      clear_out;
  data_t     clear_pc;

  modport master (
    output alloc_en, alloc_rd, alloc_inst,
    output wb_en, wb_tag, wb_val, wb_mispredict, wb_target,
    output query_tag1, query_tag2,
    input  alloc_tag, rob_full,
    input  query_ready1, query_ready2, query_val1, query_val2,
    input  commit_en, commit_Number, commit_val, commit_rd,
    input  clear_out, clear_pc
  );

  modport slave (
    input  alloc_en, alloc_rd, alloc_inst,
    input  wb_en, wb_tag, wb_val, wb_mispredict, wb_target,
    input  query_tag1, query_tag2,
    output alloc_tag, rob_full,
    output query_ready1, query_ready2, query_val1, query_val2,
    output commit_en, commit_Number, commit_val, commit_rd,
    output clear_out, clear_pc
  );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer, including the full flag
// and the flush that collapses the buffer back to empty.
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic alloc_req,
  input  logic commit_fire,
  input  logic flush,
  output ptr_t head,
  output ptr_t tail,
  output cnt_t count,
  output logic full,
  output logic alloc_ok
);

  // an allocation in the flush cycle is dropped along with everything younger
  assign alloc_ok = rdy_in && alloc_req && !flush && (count < cnt_t'(DEPTH));
  // one slot of margin for the issue stage's one-cycle latency
  assign full     = (count >= cnt_t'(DEPTH - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc_ok)    tail <= ptr_inc(tail);
        if (commit_fire) head <= ptr_inc(head);
        count <= count + cnt_t'(alloc_ok) - cnt_t'(commit_fire);
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags in program order, collects results by tag,
// retires one entry per cycle on the commit bus and raises the flush on a mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);

  rob_entry_t entries [DEPTH];

  ptr_t  head;
  ptr_t  tail;
  cnt_t  count;
  logic  full;
  logic  alloc_ok;
  logic  commit_fire;
  logic  flush;
  logic  wb_hit;
  ptr_t  wb_idx;
  ptr_t  q1_idx;
  ptr_t  q2_idx;
  logic  q1_fwd;
  logic  q2_fwd;
  logic  q1_in;
  logic  q2_in;

  logic      commit_en_q;
  tag_t      commit_num_q;
  data_t     commit_val_q;
  reg_addr_t commit_rd_q;
  logic      clear_q;
  data_t     clear_pc_q;

  // tags at or beyond DEPTH name no entry and are ignored
  assign wb_idx      = bus.wb_tag[PTR_W-1:0];
  assign wb_hit      = rdy_in && bus.wb_en && (bus.wb_tag < tag_t'(DEPTH))
                       && (entries[wb_idx].state == ST_BUSY);
  assign commit_fire = rdy_in && (count != '0) && (entries[head].state == ST_DONE);
  assign flush       = commit_fire && entries[head].mispredict;

  rob_ptr_ctrl u_ptr_ctrl (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .alloc_req   (bus.alloc_en),
    .commit_fire (commit_fire),
    .flush       (flush),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .alloc_ok    (alloc_ok)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) entries[i].state <= ST_EMPTY;
      end else begin
        if (wb_hit) begin
          entries[wb_idx].state      <= ST_DONE;
          entries[wb_idx].val        <= bus.wb_val;
          entries[wb_idx].mispredict <= bus.wb_mispredict;
          entries[wb_idx].target     <= bus.wb_target;
        end
        if (commit_fire) entries[head].state <= ST_EMPTY;
        if (alloc_ok) begin
          entries[tail].state      <= ST_BUSY;
          entries[tail].rd         <= bus.alloc_rd;
          entries[tail].mispredict <= 1'b0;
          entries[tail].inst       <= bus.alloc_inst;
        end
      end
    end
  end

  // commit bus and flush are registered pulses; payload holds between commits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_en_q  <= 1'b0;
      commit_num_q <= '0;
      commit_val_q <= '0;
      commit_rd_q  <= '0;
      clear_q      <= 1'b0;
      clear_pc_q   <= '0;
    end else begin
      commit_en_q <= 1'b0;
      clear_q     <= 1'b0;
      if (commit_fire) begin
        commit_en_q  <= 1'b1;
        commit_num_q <= tag_t'(head);
        commit_val_q <= entries[head].val;
        commit_rd_q  <= entries[head].rd;
        if (entries[head].mispredict) begin
          clear_q    <= 1'b1;
          clear_pc_q <= entries[head].target;
        end
      end
    end
  end

  assign q1_idx = bus.query_tag1[PTR_W-1:0];
  assign q2_idx = bus.query_tag2[PTR_W-1:0];
  assign q1_in  = (bus.query_tag1 < tag_t'(DEPTH));
  assign q2_in  = (bus.query_tag2 < tag_t'(DEPTH));
  assign q1_fwd = bus.wb_en && (bus.wb_tag == bus.query_tag1);
  assign q2_fwd = bus.wb_en && (bus.wb_tag == bus.query_tag2);

  assign bus.query_ready1 = q1_fwd || (q1_in && (entries[q1_idx].state == ST_DONE));
  assign bus.query_ready2 = q2_fwd || (q2_in && (entries[q2_idx].state == ST_DONE));
  assign bus.query_val1   = q1_fwd ? bus.wb_val : entries[q1_idx].val;
  assign bus.query_val2   = q2_fwd ? bus.wb_val : entries[q2_idx].val;

  assign bus.alloc_tag     = tag_t'(tail);
  assign bus.rob_full      = full;
  assign bus.commit_en     = commit_en_q;
  assign bus.commit_Number = commit_num_q;
  assign bus.commit_val    = commit_val_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.clear_out     = clear_q;
  assign bus.clear_pc      = clear_pc_q;

endmodule
